// File: rtl/if_axi_read_master.sv
// -----------------------------------------------------------------------------
// if_axi_read_master
//
// Instruction-fetch master. Turns one CPU fetch request into a single-beat
// AXI4 read (AR/R channels) and returns the 32-bit instruction. It also
// produces IM_busy, which holds the PC until the instruction is delivered.
// A branch/jump flush during a fetch lets the AXI transaction finish, so no
// response is left orphaned, and delivers NOP_INST in place of the fetched
// word.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fetch_req, fetch_addr    CPU fetch request and byte address (PC)
//   flush                    redirect; kills the fetch in progress
//   IM_busy                  fetch not complete, PC must hold
//   inst, inst_valid         delivered instruction and its one-cycle strobe
//   inst_err                 strobe with inst_valid when RRESP != OKAY
//   AR*                      AXI read-address channel (single beat, INCR)
//   R*                       AXI read-data channel
// -----------------------------------------------------------------------------
module if_axi_read_master #(
    parameter logic [3:0]  MASTER_ID = 4'd0,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        flush,
    output logic        IM_busy,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        inst_err,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] araddr_reg;
    logic        kill_reg;
    logic [31:0] inst_reg;
    logic        err_reg;

    logic        start;
    logic        r_accept;
    logic        kill_now;

    // Only one beat is ever requested, so the beat matching our ID is the
    // last one regardless of what RLAST says.
    logic        unused_rlast;
    assign unused_rlast = RLAST;

    assign start    = (state_reg == IDLE) && fetch_req && !flush;
    assign r_accept = (state_reg == DATA) && RVALID && (RID == MASTER_ID);
    // A flush arriving on the very cycle the beat is captured still kills it.
    assign kill_now = kill_reg || flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            araddr_reg <= 32'd0;
            kill_reg   <= 1'b0;
            inst_reg   <= NOP_INST;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                araddr_reg <= fetch_addr;
            end
            // DONE always leads to IDLE, so clearing here clears on IDLE entry.
            if (state_reg == DONE) begin
                kill_reg <= 1'b0;
            end else if (((state_reg == ADDR) || (state_reg == DATA)) && flush) begin
                kill_reg <= 1'b1;
            end
            // Resolve the delivered word at capture time so DONE only replays it.
            if (r_accept) begin
                inst_reg <= (kill_now || (RRESP != 2'b00)) ? NOP_INST : RDATA;
                err_reg  <= (RRESP != 2'b00) && !kill_now;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        IM_busy    = 1'b0;
        inst_valid = 1'b0;
        inst_err   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Busy in the request cycle itself so the PC does not advance
                // before the fetch has even been issued.
                IM_busy = fetch_req;
                if (start) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                // ARVALID stays up until ARREADY even across a flush.
                ARVALID = 1'b1;
                IM_busy = 1'b1;
                if (ARREADY) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                // Beats carrying another ID are consumed and dropped.
                RREADY  = 1'b1;
                IM_busy = 1'b1;
                if (r_accept) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                inst_valid = 1'b1;
                inst_err   = err_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            IM_busy = 1'b0;
        end
    end

    assign inst    = inst_reg;
    assign ARID    = MASTER_ID;
    assign ARADDR  = araddr_reg;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

endmodule

// File: tb/tb_if_axi_read_master.sv
module tb_if_axi_read_master;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        IM_busy;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_err;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int checks   = 0;
    int failures = 0;

    if_axi_read_master #(
        .MASTER_ID (4'd0),
        .NOP_INST  (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .flush      (flush),
        .IM_busy    (IM_busy),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_err   (inst_err),
        .ARID       (ARID),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARSIZE     (ARSIZE),
        .ARBURST    (ARBURST),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RID        (RID),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RLAST      (RLAST),
        .RVALID     (RVALID),
        .RREADY     (RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ar_wait;    // ADDR cycles before ARREADY
        int          r_wait;     // DATA cycles before RVALID
        logic [31:0] rdata;
        logic [1:0]  rresp;
        bit          bad_id;     // send one RID=3 beat before the real one
        int          flush_cyc;  // cycle of a one-cycle flush, -1 for none
        logic [31:0] exp_inst;
        logic        exp_err;
        int          exp_lat;    // cycle of inst_valid, request cycle = 0
    } txn_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0;
        flush     = 1'b0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RID       = 4'd0;
        RDATA     = 32'd0;
        RRESP     = 2'b00;
        RLAST     = 1'b1;
    endtask

    // Drives one fetch with a simple AXI slave model and reports what was seen.
    task automatic run_txn(input txn_t t, output int lat, output logic [31:0] got_inst,
                           output logic got_err, output int ar_cycles, output bit addr_ok,
                           output bit busy_ok, output bit post_ok);
        int r_cnt    = 0;
        bit bad_sent = 1'b0;
        lat       = -1;
        got_inst  = 32'hx;
        got_err   = 1'bx;
        ar_cycles = 0;
        addr_ok   = 1'b1;
        busy_ok   = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            fetch_req = 1'b1;
            // Once the fetch is underway the address bus wanders; the latched one must be used.
            fetch_addr = (ARVALID || RREADY) ? (t.addr ^ 32'hFFFF_0000) : t.addr;
            flush   = (c == t.flush_cyc);
            ARREADY = 1'b0;
            if (ARVALID) begin
                if (ARADDR !== t.addr) addr_ok = 1'b0;
                ARREADY = (ar_cycles >= t.ar_wait);
                ar_cycles++;
            end
            RVALID = 1'b0;
            RID    = 4'd0;
            RDATA  = 32'h0;
            RRESP  = 2'b00;
            if (RREADY) begin
                if (r_cnt >= t.r_wait) begin
                    RVALID = 1'b1;
                    if (t.bad_id && !bad_sent) begin
                        RID      = 4'd3;
                        RDATA    = 32'hBAD0_0BAD;
                        RRESP    = 2'b10;
                        bad_sent = 1'b1;
                    end else begin
                        RDATA = t.rdata;
                        RRESP = t.rresp;
                    end
                end
                r_cnt++;
            end
            #1;
            if (inst_valid) begin
                if (IM_busy !== 1'b0) busy_ok = 1'b0;
                lat      = c;
                got_inst = inst;
                got_err  = inst_err;
                break;
            end
            if (IM_busy !== 1'b1) busy_ok = 1'b0;
        end
        @(posedge clk); #1;
        idle_inputs();
        #1;
        post_ok = (inst_valid === 1'b0) && (inst_err === 1'b0) && (IM_busy === 1'b0);
    endtask

    initial begin
        txn_t        tv[10];
        int          lat, arc;
        logic [31:0] gi;
        logic        ge;
        bit          aok, bok, pok;
        int          nv, nar;
        int          vcyc[2];
        logic [31:0] vinst[2];
        logic [31:0] aaddr[2];

        //         addr          arw rw rdata          rresp bad  flush exp_inst       err lat
        tv[0] = '{32'h0000_0100, 0, 0, 32'h00A0_0093, 2'b00, 1'b0, -1, 32'h00A0_0093, 1'b0, 3};
        tv[1] = '{32'h0000_0200, 3, 1, 32'h1234_5678, 2'b00, 1'b0, -1, 32'h1234_5678, 1'b0, 7};
        tv[2] = '{32'h0000_0300, 0, 2, 32'hDEAD_BEEF, 2'b00, 1'b0,  3, NOP,           1'b0, 5};
        tv[3] = '{32'h0000_0304, 2, 0, 32'hCAFE_F00D, 2'b00, 1'b0,  1, NOP,           1'b0, 5};
        tv[4] = '{32'h0000_0308, 0, 0, 32'h1111_1111, 2'b00, 1'b0,  2, NOP,           1'b0, 3};
        tv[5] = '{32'h0000_030C, 0, 0, 32'h2222_2222, 2'b00, 1'b0,  3, 32'h2222_2222, 1'b0, 3};
        tv[6] = '{32'h0000_0400, 1, 1, 32'h3333_3333, 2'b10, 1'b0, -1, NOP,           1'b1, 5};
        tv[7] = '{32'h0000_0404, 0, 1, 32'h4444_4444, 2'b11, 1'b0,  2, NOP,           1'b0, 4};
        tv[8] = '{32'h0000_0500, 0, 0, 32'h5555_5555, 2'b00, 1'b1, -1, 32'h5555_5555, 1'b0, 4};
        tv[9] = '{32'h0000_0600, 0, 0, 32'h6666_6666, 2'b00, 1'b0,  0, 32'h6666_6666, 1'b0, 4};

        // Reset state, with a request pending to show IM_busy is forced low.
        idle_inputs();
        fetch_addr = 32'h0000_1234;
        rst        = 1'b1;
        fetch_req  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",       {31'd0, IM_busy},    32'd0);
        chk("rst_arvalid",    {31'd0, ARVALID},    32'd0);
        chk("rst_rready",     {31'd0, RREADY},     32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_err",   {31'd0, inst_err},   32'd0);
        chk("rst_inst",       inst,                NOP);
        chk("rst_araddr",     ARADDR,              32'd0);
        chk("const_ar",       {ARID, ARLEN, ARSIZE, ARBURST}, {4'd0, 4'd0, 3'b010, 2'b01});
        fetch_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_txn(tv[i], lat, gi, ge, arc, aok, bok, pok);
            $display("txn %0d addr=%h lat=%0d inst=%h err=%0d ar_cycles=%0d", i, tv[i].addr, lat, gi, ge, arc);
            chk($sformatf("v%0d_lat", i),     lat,             tv[i].exp_lat);
            chk($sformatf("v%0d_inst", i),    gi,              tv[i].exp_inst);
            chk($sformatf("v%0d_err", i),     {31'd0, ge},     {31'd0, tv[i].exp_err});
            chk($sformatf("v%0d_ar_cyc", i),  arc,             tv[i].ar_wait + 1);
            chk($sformatf("v%0d_araddr", i),  {31'd0, aok},    32'd1);
            chk($sformatf("v%0d_busy", i),    {31'd0, bok},    32'd1);
            chk($sformatf("v%0d_onepulse", i), {31'd0, pok},   32'd1);
        end

        // Back-to-back: fetch_req held, slave always ready.
        nv  = 0;
        nar = 0;
        vcyc[0] = -1; vcyc[1] = -1;
        vinst[0] = 32'hx; vinst[1] = 32'hx;
        aaddr[0] = 32'hx; aaddr[1] = 32'hx;
        @(posedge clk); #1;
        for (int c = 0; c < 20 && nv < 2; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            fetch_req  = 1'b1;
            fetch_addr = (nv == 0) ? 32'h0 : 32'h4;
            ARREADY    = ARVALID;
            if (ARVALID && nar < 2) begin
                aaddr[nar] = ARADDR;
                nar++;
            end
            RVALID = RREADY;
            RID    = 4'd0;
            RRESP  = 2'b00;
            RDATA  = (nv == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
            #1;
            if (inst_valid) begin
                vcyc[nv]  = c;
                vinst[nv] = inst;
                nv++;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        $display("b2b pulses at %0d,%0d araddr=%h,%h inst=%h,%h", vcyc[0], vcyc[1], aaddr[0], aaddr[1], vinst[0], vinst[1]);
        chk("b2b_cyc0",  vcyc[0],  3);
        chk("b2b_cyc1",  vcyc[1],  7);
        chk("b2b_addr0", aaddr[0], 32'h0);
        chk("b2b_addr1", aaddr[1], 32'h4);
        chk("b2b_inst0", vinst[0], 32'hAAAA_0001);
        chk("b2b_inst1", vinst[1], 32'hBBBB_0002);

        // Reset asserted in ADDR: ARVALID must drop without a clock edge.
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0ABC;
        @(posedge clk); #1;
        chk("mid_arvalid_pre", {31'd0, ARVALID}, 32'd1);
        rst = 1'b1;
        #1;
        $display("midrst arvalid=%0d busy=%0d inst=%h", ARVALID, IM_busy, inst);
        chk("mid_arvalid",  {31'd0, ARVALID}, 32'd0);
        chk("mid_busy",     {31'd0, IM_busy}, 32'd0);
        chk("mid_inst",     inst,             NOP);
        chk("mid_araddr",   ARADDR,           32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk("post_rst_busy", {31'd0, IM_busy}, 32'd0);
        @(posedge clk); #2;
        chk("post_rst_idle", {30'd0, ARVALID, RREADY}, 32'd0);

        // A normal fetch still works after the mid-flight reset.
        run_txn(tv[0], lat, gi, ge, arc, aok, bok, pok);
        $display("txn after reset addr=%h lat=%0d inst=%h err=%0d", tv[0].addr, lat, gi, ge);
        chk("after_rst_lat",  lat, 3);
        chk("after_rst_inst", gi,  32'h00A0_0093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
